// File: rtl/sccb_responder.sv
// sccb_responder: camera-side SCCB target that stands in for an image sensor.
// Oversamples SIO_C/SIO_D on XCLK, decodes start/stop and the ID, sub-address
// and data phases, and serves a 256 x 8 register array over the 2-wire bus.
module sccb_responder #(
   parameter logic [7:0] DEV_ID = 8'h42,
   parameter bit         ACK_EN = 1'b1
) (
   input  logic       XCLK,
   input  logic       RST,
   input  logic       SIO_C,
   inout  wire        SIO_D,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       id_err
);

   typedef enum logic [3:0] {
      IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE
   } state_t;

   state_t     state;
   logic [2:0] c_sync;
   logic [2:0] d_sync;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic [7:0] rd_shift;
   logic [7:0] ptr;
   logic       rw;
   logic       ack_half;
   logic       drv_oe;
   logic       drv_val;
   logic [7:0] regs [256];

   logic       c_rise;
   logic       c_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] next_byte;
   logic       commit;

   // Bit 2 of each chain is the previous synchronised value, so comparing it
   // with bit 1 gives the edge one cycle after the value has settled.
   assign c_rise    = c_sync[1] & ~c_sync[2];
   assign c_fall    = ~c_sync[1] & c_sync[2];
   assign start_det = c_sync[1] & c_sync[2] & d_sync[2] & ~d_sync[1];
   assign stop_det  = c_sync[1] & c_sync[2] & ~d_sync[2] & d_sync[1];
   assign next_byte = {shift, d_sync[1]};
   assign commit    = !RST && !stop_det && !start_det && (state == WDATA)
                      && c_rise && (bit_cnt == 3'd7);

   assign SIO_D = drv_oe ? drv_val : 1'bz;

   // Two-flop synchronisers plus an edge-detect flop; reset to the idle-high bus level.
   always_ff @(posedge XCLK) begin
      if (RST) begin
         c_sync <= 3'b111;
         d_sync <= 3'b111;
      end else begin
         c_sync <= {c_sync[1:0], SIO_C};
         d_sync <= {d_sync[1:0], SIO_D};
      end
   end

   // Protocol FSM: start/stop override everything, bits shift in on SIO_C rising edges.
   always_ff @(posedge XCLK) begin
      if (RST) begin
         state     <= IDLE;
         ptr       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rd_shift  <= '0;
         rw        <= 1'b0;
         ack_half  <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         id_err    <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         id_err    <= 1'b0;
         if (stop_det) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (start_det) begin
            state   <= ID;
            bit_cnt <= '0;
            busy    <= 1'b1;
         end else begin
            case (state)
               ID: if (c_rise) begin
                  shift   <= next_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (next_byte[7:1] == DEV_ID[7:1]) begin
                        rw       <= next_byte[0];
                        ack_half <= 1'b0;
                        state    <= ID_X;
                     end else begin
                        id_err <= 1'b1;
                        state  <= IGNORE;
                     end
                  end
               end
               SUB: if (c_rise) begin
                  shift   <= next_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr      <= next_byte;
                     ack_half <= 1'b0;
                     state    <= SUB_X;
                  end
               end
               WDATA: if (c_rise) begin
                  shift   <= next_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     wr_strobe <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= next_byte;
                     ack_half  <= 1'b0;
                     state     <= WDATA_X;
                  end
               end
               ID_X, SUB_X, WDATA_X: if (c_fall) begin
                  if (!ack_half) begin
                     ack_half <= 1'b1;
                  end else begin
                     ack_half <= 1'b0;
                     bit_cnt  <= '0;
                     if (state == ID_X && rw) begin
                        state    <= RDATA;
                        rd_shift <= regs[ptr];
                     end else if (state == ID_X) begin
                        state <= SUB;
                     end else if (state == SUB_X) begin
                        state <= WDATA;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               RDATA: if (c_fall) begin
                  if (bit_cnt == 3'd7) begin
                     state <= RDATA_X;
                  end else begin
                     rd_shift <= {rd_shift[6:0], 1'b0};
                     bit_cnt  <= bit_cnt + 3'd1;
                  end
               end
               RDATA_X: if (c_fall) begin
                  state <= IGNORE;
               end
               IDLE, IGNORE: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Register array write port; deliberately unreset so contents survive RST.
   always_ff @(posedge XCLK) begin
      if (commit) begin
         regs[ptr] <= next_byte;
      end
   end

   // Debug read port, one cycle of latency.
   always_ff @(posedge XCLK) begin
      if (RST) begin
         dbg_data <= '0;
      end else begin
         dbg_data <= regs[dbg_addr];
      end
   end

   // Registered pad drive so the decoded state never glitches onto SIO_D.
   always_ff @(posedge XCLK) begin
      if (RST) begin
         drv_oe  <= 1'b0;
         drv_val <= 1'b1;
      end else begin
         drv_oe  <= 1'b0;
         drv_val <= 1'b1;
         case (state)
            ID_X, SUB_X, WDATA_X: begin
               if (ack_half && ACK_EN) begin
                  drv_oe  <= 1'b1;
                  drv_val <= 1'b0;
               end
            end
            RDATA: begin
               drv_oe  <= 1'b1;
               drv_val <= rd_shift[7];
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bit-banged SCCB master driving sccb_responder, with a
// register-array model of what every write and read should do.
module tb_sccb_responder;

   localparam int         Q      = 4;
   localparam int         H      = 8;
   localparam logic [7:0] DEV_ID = 8'h42;

   logic       xclk = 1'b0;
   logic       rst;
   logic       scl;
   logic       m_low;
   logic [7:0] dbg_addr;
   logic [7:0] dbg_data;
   logic       wr_strobe;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       id_err;
   wire        sio_d;

   int total = 0;
   int bad = 0;
   int strobe_cnt = 0;
   int id_err_cnt = 0;
   int exp_strobes = 0;
   int exp_id_errs = 0;
   logic [7:0] exp_wr_addr = '0;
   logic [7:0] exp_wr_data = '0;
   logic [7:0] model_mem [256];
   logic [7:0] model_ptr = '0;
   logic [7:0] written [$];

   always #5 xclk = ~xclk;

   assign sio_d = m_low ? 1'b0 : 1'bz;
   pullup pu_sda (sio_d);

   sccb_responder #(.DEV_ID(DEV_ID), .ACK_EN(1'b1)) dut (
      .XCLK      (xclk),
      .RST       (rst),
      .SIO_C     (scl),
      .SIO_D     (sio_d),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .id_err    (id_err)
   );

   // Count single-cycle pulses so transactions can be checked for how many occurred.
   always @(negedge xclk) begin
      if (wr_strobe) strobe_cnt++;
      if (id_err) id_err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge xclk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic low, input int cycles);
      scl   = c;
      m_low = low;
      tick(cycles);
   endtask

   // Each bit slot starts with the SIO_C falling edge and ends with SIO_C high.
   task automatic sendBit(input logic b);
      applyStimulus(1'b0, m_low, Q);
      applyStimulus(1'b0, !b, Q);
      applyStimulus(1'b1, !b, H);
   endtask

   task automatic sampleSlot(output logic v);
      applyStimulus(1'b0, m_low, Q);
      applyStimulus(1'b0, 1'b0, Q);
      applyStimulus(1'b1, 1'b0, H / 2);
      v = sio_d;
      applyStimulus(1'b1, 1'b0, H / 2);
   endtask

   task automatic sendByte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sendBit(b[i]);
   endtask

   task automatic readByte(output logic [7:0] v);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         sampleSlot(s);
         v[i] = s;
      end
   endtask

   task automatic busStart();
      applyStimulus(1'b0, m_low, Q);
      applyStimulus(1'b0, 1'b0, Q);
      applyStimulus(1'b1, 1'b0, Q);
      applyStimulus(1'b1, 1'b1, H);
   endtask

   task automatic busStop();
      applyStimulus(1'b0, m_low, Q);
      applyStimulus(1'b0, 1'b1, Q);
      applyStimulus(1'b1, 1'b1, Q);
      applyStimulus(1'b1, 1'b0, H);
   endtask

   task automatic doWrite(input string tag, input logic [7:0] sub, input logic [7:0] data, input bit full);
      logic a;
      busStart();
      sendByte(DEV_ID & 8'hFE);
      sampleSlot(a);
      checkOutput({tag, "_ack_id"}, 32'(a), 32'd0);
      sendByte(sub);
      sampleSlot(a);
      checkOutput({tag, "_ack_sub"}, 32'(a), 32'd0);
      model_ptr = sub;
      if (full) begin
         sendByte(data);
         sampleSlot(a);
         checkOutput({tag, "_ack_data"}, 32'(a), 32'd0);
         model_mem[sub] = data;
         written.push_back(sub);
         exp_strobes++;
         exp_wr_addr = sub;
         exp_wr_data = data;
      end
      busStop();
      checkOutput({tag, "_strobes"}, 32'(strobe_cnt), 32'(exp_strobes));
      checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_wr_addr));
      checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'(exp_wr_data));
   endtask

   task automatic doRead(input string tag);
      logic       a;
      logic [7:0] v;
      busStart();
      sendByte(DEV_ID | 8'h01);
      sampleSlot(a);
      checkOutput({tag, "_ack_id"}, 32'(a), 32'd0);
      readByte(v);
      sampleSlot(a);
      busStop();
      checkOutput({tag, "_data"}, 32'(v), 32'(model_mem[model_ptr]));
      checkOutput({tag, "_strobes"}, 32'(strobe_cnt), 32'(exp_strobes));
   endtask

   task automatic checkDbg(input string tag, input logic [7:0] addr);
      dbg_addr = addr;
      tick(2);
      checkOutput(tag, 32'(dbg_data), 32'(model_mem[addr]));
   endtask

   initial begin
      logic       a;
      logic [7:0] v;
      logic [7:0] addr;
      logic [7:0] data;

      rst      = 1'b1;
      scl      = 1'b1;
      m_low    = 1'b0;
      dbg_addr = 8'h00;
      tick(4);
      $display("[TB] reset state");
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_strobe", 32'(wr_strobe), 32'd0);
      checkOutput("rst_id_err", 32'(id_err), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
      checkOutput("rst_dbg", 32'(dbg_data), 32'd0);
      checkOutput("rst_sda", 32'(sio_d), 32'd1);
      rst = 1'b0;
      tick(4);

      $display("[TB] 3-phase write");
      doWrite("w3", 8'h12, 8'h80, 1'b1);
      checkDbg("w3_dbg", 8'h12);
      doWrite("w0", 8'h00, 8'hA5, 1'b1);

      $display("[TB] address set then read");
      doWrite("pre0a", 8'h0A, 8'h76, 1'b1);
      doWrite("set0a", 8'h0A, 8'h00, 1'b0);
      doRead("rd0a");

      $display("[TB] wrong ID");
      busStart();
      checkOutput("wid_busy", 32'(busy), 32'd1);
      sendByte(8'h60);
      sampleSlot(a);
      checkOutput("wid_ack_id", 32'(a), 32'd1);
      sendByte(8'h12);
      sampleSlot(a);
      checkOutput("wid_ack_sub", 32'(a), 32'd1);
      sendByte(8'h55);
      sampleSlot(a);
      checkOutput("wid_ack_data", 32'(a), 32'd1);
      busStop();
      exp_id_errs++;
      checkOutput("wid_id_err", 32'(id_err_cnt), 32'(exp_id_errs));
      checkOutput("wid_strobes", 32'(strobe_cnt), 32'(exp_strobes));
      checkDbg("wid_dbg", 8'h12);

      $display("[TB] truncated write");
      doWrite("pre20", 8'h20, 8'h3C, 1'b1);
      busStart();
      sendByte(DEV_ID);
      sampleSlot(a);
      sendByte(8'h20);
      sampleSlot(a);
      model_ptr = 8'h20;
      for (int i = 0; i < 4; i++) sendBit(1'b0);
      applyStimulus(1'b0, m_low, Q);
      applyStimulus(1'b0, 1'b1, Q);
      applyStimulus(1'b1, 1'b1, Q);
      applyStimulus(1'b1, 1'b0, 2);
      checkOutput("trunc_busy_pre", 32'(busy), 32'd1);
      tick(1);
      checkOutput("trunc_busy_post", 32'(busy), 32'd0);
      tick(H - 3);
      checkOutput("trunc_strobes", 32'(strobe_cnt), 32'(exp_strobes));
      checkDbg("trunc_dbg", 8'h20);
      doRead("trunc_rd");

      $display("[TB] repeated start");
      doWrite("pre05", 8'h05, 8'($urandom), 1'b1);
      doWrite("pre06", 8'h06, 8'($urandom), 1'b1);
      busStart();
      sendByte(DEV_ID);
      sampleSlot(a);
      checkOutput("rs_ack_id", 32'(a), 32'd0);
      sendByte(8'h05);
      sampleSlot(a);
      checkOutput("rs_ack_sub", 32'(a), 32'd0);
      model_ptr = 8'h05;
      busStart();
      sendByte(DEV_ID | 8'h01);
      sampleSlot(a);
      checkOutput("rs_ack_rd", 32'(a), 32'd0);
      readByte(v);
      sampleSlot(a);
      busStop();
      checkOutput("rs_data", 32'(v), 32'(model_mem[8'h05]));
      doRead("rs_ptr_kept");

      $display("[TB] randomized writes and reads");
      for (int n = 0; n < 6; n++) begin
         addr = 8'($urandom_range(0, 255));
         data = 8'($urandom);
         doWrite("rnd_w", addr, data, 1'b1);
         checkDbg("rnd_dbg", addr);
         addr = written[$urandom_range(0, written.size() - 1)];
         doWrite("rnd_set", addr, 8'h00, 1'b0);
         doRead("rnd_rd");
      end

      $display("[TB] reset mid-read");
      doWrite("pre33", 8'h33, 8'h00, 1'b1);
      busStart();
      sendByte(DEV_ID | 8'h01);
      sampleSlot(a);
      checkOutput("mr_ack_id", 32'(a), 32'd0);
      for (int i = 0; i < 4; i++) sampleSlot(a);
      applyStimulus(1'b0, 1'b0, Q);
      applyStimulus(1'b0, 1'b0, Q);
      applyStimulus(1'b1, 1'b0, H / 2);
      checkOutput("mr_sda_driven", 32'(sio_d), 32'd0);
      rst = 1'b1;
      tick(1);
      checkOutput("mr_sda_rel", 32'(sio_d), 32'd1);
      checkOutput("mr_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, H / 2 - 1);
      busStop();
      model_ptr = 8'h00;
      doRead("mr_ptr0");
      doWrite("mr_w", 8'h77, 8'($urandom), 1'b1);
      doRead("mr_rd");
      checkOutput("final_id_err", 32'(id_err_cnt), 32'(exp_id_errs));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sccb_responder.md
# sccb_responder

Camera-side SCCB target used to bench and emulate the 2-wire SCCB master without a physical sensor. It oversamples SIO_C/SIO_D on XCLK, decodes start/stop and the ID/sub-address/data phases, and holds a 256 x 8 register array. It accepts 3-phase writes, 2-phase address-set writes and 2-phase reads, driving read data onto SIO_D. It sits on the SCCB pins opposite the master; its write strobe and debug port feed the test harness.

## Interface
- DEV_ID, 8'h42: write ID; bit 0 is ignored on compare, and the read ID is DEV_ID|1.
- ACK_EN, 1: 1 drives SIO_D low during the 9th (don't-care) bit of ID, sub-address and write-data phases when addressed; 0 leaves the bus released.

- XCLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- SIO_C  in  1  SCCB clock from the master.
- SIO_D  inout  1  SCCB data; driven only low or with read data, otherwise 1'bz.
- dbg_addr  in  8  debug register select.
- dbg_data  out  8  registered reg[dbg_addr], 1-cycle latency.
- wr_strobe  out  1  1-cycle pulse when a write-data byte is committed.
- wr_addr  out  8  address of the committed write; held until the next write.
- wr_data  out  8  data of the committed write; held until the next write.
- busy  out  1  high from a start condition until stop or reset.
- id_err  out  1  1-cycle pulse when the ID does not match DEV_ID[7:1].

## Operation
- **Input synchronisation:** SIO_C and SIO_D (pad value) pass through 2-flop synchronisers; a third flop provides edge detection.
- **Condition decode:**
  - Start: SIO_D falls while SIO_C is high.
  - Stop: SIO_D rises while SIO_C is high.
  - Data bits are sampled on the SIO_C rising edge, MSB first.
- **States:** IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE.
- **Transitions:**
  - Start from any state → ID, bit counter = 0. Repeated start is legal.
  - Stop from any state → IDLE, bus released.
  - ID: after 8 bits, a mismatch pulses id_err → IGNORE; a match → ID_X, latching rw = bit0.
  - ID_X: ends on the SIO_C falling edge. rw=0 → SUB; rw=1 → RDATA.
  - SUB: after 8 bits, ptr <= byte → SUB_X → WDATA.
  - WDATA: after 8 bits, reg[ptr] <= byte and wr_strobe/wr_addr/wr_data update in the same cycle → WDATA_X → IGNORE.
    - No auto-increment.
    - A stop before 8 bits discards the byte (2-phase write = address set only).
  - RDATA: the shift register loads reg[ptr] when entering the state. Each SIO_C falling edge drives the next bit; bit 7 is driven immediately on entry.
  - After the 8th falling edge → RDATA_X: bus released, the master's NA bit is ignored → IGNORE.
  - IGNORE: SIO_D released until start or stop.
- **SIO_D drive enable:**
  - ID_X, SUB_X and WDATA_X with ACK_EN=1: drive 0.
  - RDATA: drive the read shift bit.
  - All other states: z.
- **Register array:** not reset; contents are preserved across RST. ptr resets to 0.
- **Reset mid-transaction:** the transaction is abandoned. A partial write never commits.

## Timing
- Reset values:
  - SIO_D = z; busy, wr_strobe and id_err = 0.
  - wr_addr, wr_data and dbg_data = 0.
  - State = IDLE, ptr = 0.
- Pad edge to internal detection: 3 XCLK cycles.
- SIO_C high and low phases must each be ≥ 4 XCLK cycles. SIO_D must be stable ≥ 4 XCLK around SIO_C rising edges.
- Read data is valid on SIO_D 3-4 XCLK after the SIO_C falling edge, well before the next rising edge.
- Release at the end of RDATA and of the *_X states: 3-4 XCLK after the SIO_C falling edge.
- wr_strobe asserts 3 XCLK after the 8th data SIO_C rising edge.
- RST is observed at the next XCLK edge. SIO_D goes z and busy goes 0 after that edge.
- Simultaneous start and stop detect cannot occur, since a single SIO_D edge produces only one of them. Stop takes priority over bit sampling in the same cycle.

## Test plan
- **3-phase write:** ID 0x42, sub 0x12, data 0x80 → one wr_strobe with wr_addr=0x12, wr_data=0x80; dbg_addr=0x12 gives dbg_data=0x80; SIO_D driven low in each 9th bit.
- **Address set then read:** preload reg[0x0A]=0x76 via a write; 2-phase write sub 0x0A, stop, start, ID 0x43 → SIO_D carries 0,1,1,1,0,1,1,0 on successive clocks; no wr_strobe during the read.
- **Wrong ID:** ID 0x60 with a full 3-phase write → id_err pulses once; SIO_D stays z throughout; no wr_strobe; reg contents unchanged.
- **Truncated write:** stop after 4 data bits → no wr_strobe; busy falls 3 XCLK after stop; state = IDLE.
- **Reset mid-read:** RST asserted during RDATA bit 3 → SIO_D = z and busy = 0 after 1 XCLK; the next full transaction decodes correctly.
- **Repeated start:** start, ID 0x42, sub 0x05, repeated start, then a full read → returns reg[0x05]; ptr=0x05 is retained.
